// File: rtl/led_pkg.sv
// Shared LED output-stage definitions: channel count, PWM width, ramp
// direction encoding and the brightness-nibble to PWM-level mapping.
package led_pkg;

   localparam int unsigned LED_N = 4;
   localparam int unsigned PWM_W = 8;

   typedef logic [PWM_W-1:0] level_t;

   typedef enum logic [1:0] {
      RAMP_HOLD,
      RAMP_UP,
      RAMP_DOWN,
      RAMP_SNAP
   } ramp_e;

   // Nibble replication maps F -> FF and 0 -> 00 with an even spread between.
   function automatic level_t bright_to_level(input logic [3:0] bright);
      return {bright, bright};
   endfunction

endpackage

// File: rtl/led_pwm_fader_if.sv
// Pattern/brightness inputs and PWM drive outputs of the LED output stage.
interface led_pwm_fader_if;
   import led_pkg::*;

   logic [LED_N-1:0] i_led_in;
   logic [3:0]       i_brightness;
   logic             i_fade_en;
   logic [LED_N-1:0] o_led;
   logic             o_busy;

   modport master (
      output i_led_in,
      output i_brightness,
      output i_fade_en,
      input  o_led,
      input  o_busy
   );

   modport slave (
      input  i_led_in,
      input  i_brightness,
      input  i_fade_en,
      output o_led,
      output o_busy
   );

endinterface

// File: rtl/led_fade_channel.sv
// One LED channel: level register with saturating ramp toward its target,
// plus the registered PWM compare against the shared counter.
module led_fade_channel
   import led_pkg::*;
#(
   parameter int unsigned STEP = 1
) (
   input  logic   clk,
   input  logic   rst_n,
   input  level_t target,
   input  logic   fade,
   input  logic   tick,
   input  level_t pwm_cnt,
   output logic   led,
   output logic   busy_next
);

   level_t             level;
   level_t             level_next;
   ramp_e              ramp;
   logic [PWM_W:0]     up_sum;
   logic [PWM_W:0]     dn_diff;

   always_comb begin
      up_sum  = {1'b0, level} + (PWM_W+1)'(STEP);
      dn_diff = {1'b0, level} - (PWM_W+1)'(STEP);

      ramp = RAMP_HOLD;
      if (!fade)
         ramp = RAMP_SNAP;
      else if (tick && (level < target))
         ramp = RAMP_UP;
      else if (tick && (level > target))
         ramp = RAMP_DOWN;

      // Ninth bit catches overflow on the way up and borrow on the way down.
      level_next = level;
      case (ramp)
         RAMP_SNAP: level_next = target;
         RAMP_UP:   level_next = (up_sum >= {1'b0, target}) ? target : up_sum[PWM_W-1:0];
         RAMP_DOWN: level_next = (dn_diff[PWM_W] || (dn_diff[PWM_W-1:0] <= target))
                                 ? target : dn_diff[PWM_W-1:0];
         default:   level_next = level;
      endcase

      busy_next = (level_next != target);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level <= '0;
         led   <= 1'b0;
      end else begin
         level <= level_next;
         led   <= (level == '1) | (level > pwm_cnt);
      end
   end

endmodule

// File: rtl/led_pwm_fader.sv
// LED output stage: registers the controller pattern, shares the PWM counter
// and fade divider across channels, and reports whether any ramp is active.
module led_pwm_fader
   import led_pkg::*;
#(
   parameter int unsigned FADE_DIV = 196078,
   parameter int unsigned STEP     = 1
) (
   input  logic            i_axi_aclk_100MHZ,
   input  logic            i_rstn,
   led_pwm_fader_if.slave  bus
);

   localparam int unsigned DIV_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

   logic [LED_N-1:0] led_q;
   logic [3:0]       bright_q;
   logic             fade_q;
   level_t           pwm_cnt;
   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   level_t           target_q [LED_N];
   logic [LED_N-1:0] led_w;
   logic [LED_N-1:0] busy_w;

   assign tick = (div_cnt == DIV_W'(FADE_DIV - 1));

   always_ff @(posedge i_axi_aclk_100MHZ or negedge i_rstn) begin
      if (!i_rstn) begin
         led_q    <= '0;
         bright_q <= '0;
         fade_q   <= 1'b0;
         pwm_cnt  <= '0;
         div_cnt  <= '0;
         bus.o_busy <= 1'b0;
      end else begin
         led_q    <= bus.i_led_in;
         bright_q <= bus.i_brightness;
         fade_q   <= bus.i_fade_en;
         pwm_cnt  <= pwm_cnt + 1'b1;
         div_cnt  <= tick ? '0 : div_cnt + 1'b1;
         bus.o_busy <= |busy_w;
      end
   end

   // Targets decode straight from the input registers to keep the 3-cycle path.
   always_comb begin
      for (int unsigned i = 0; i < LED_N; i++)
         target_q[i] = led_q[i] ? bright_to_level(bright_q) : '0;
   end

   for (genvar i = 0; i < LED_N; i++) begin : g_ch
      led_fade_channel #(
         .STEP (STEP)
      ) u_ch (
         .clk       (i_axi_aclk_100MHZ),
         .rst_n     (i_rstn),
         .target    (target_q[i]),
         .fade      (fade_q),
         .tick      (tick),
         .pwm_cnt   (pwm_cnt),
         .led       (led_w[i]),
         .busy_next (busy_w[i])
      );
   end

   assign bus.o_led = led_w;

endmodule
